// File: rtl/nv_ram_rwsp_80x514_fifo_if.sv
// Producer/consumer valid-ready handshake plus the two-port RAM port bundle.
// The slave modport is the FIFO controller; the master modport is everything around it.
interface nv_ram_rwsp_80x514_fifo_if #(
    parameter int WIDTH = 514,
    parameter int AW    = 7
);
    logic             wr_pvld;
    logic             wr_prdy;
    logic [WIDTH-1:0] wr_pd;
    logic             rd_pvld;
    logic             rd_prdy;
    logic [WIDTH-1:0] rd_pd;
    logic             ram_we;
    logic [AW-1:0]    ram_wa;
    logic [WIDTH-1:0] ram_di;
    logic             ram_re;
    logic [AW-1:0]    ram_ra;
    logic             ram_ore;
    logic [WIDTH-1:0] ram_dout;
    logic [31:0]      pwrbus_ram_pd;

    modport slave (
        input  wr_pvld, wr_pd, rd_prdy, ram_dout, pwrbus_ram_pd,
        output wr_prdy, rd_pvld, rd_pd, ram_we, ram_wa, ram_di, ram_re, ram_ra, ram_ore
    );

    modport master (
        output wr_pvld, wr_pd, rd_prdy, ram_dout, pwrbus_ram_pd,
        input  wr_prdy, rd_pvld, rd_pd, ram_we, ram_wa, ram_di, ram_re, ram_ra, ram_ore
    );
endinterface

// File: rtl/nv_ram_rwsp_80x514_fifo.sv
// Valid/ready FIFO controller around an 80x514 two-port RAM; the RAM's address
// register and output register form the two read stages, so no payload is stored here.
module nv_ram_rwsp_80x514_fifo #(
    parameter int DEPTH = 80,
    parameter int WIDTH = 514,
    parameter int AW    = 7
) (
    input  logic                    nvdla_core_clk,
    input  logic                    nvdla_core_rstn,
    nv_ram_rwsp_80x514_fifo_if.slave bus
);
    localparam int            CW   = $clog2(DEPTH + 1);
    localparam logic [CW-1:0] FULL = CW'(DEPTH);
    localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);

    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [CW-1:0]    occ;
    logic [CW-1:0]    unrd;
    logic [CW-1:0]    occ_nxt;
    logic [CW-1:0]    unrd_nxt;
    logic             s1_vld;
    logic             s2_vld;
    logic             wr_rdy;
    logic             push;
    logic             pop;
    logic             adv;
    logic             iss;
    logic [WIDTH-1:0] wr_data;
    logic [WIDTH-1:0] rd_data;

    function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
        return (p == LAST) ? '0 : p + 1'b1;
    endfunction

    // Ready is gated by reset so it drops immediately and rises on the first released cycle.
    assign wr_rdy  = nvdla_core_rstn & (occ < FULL);
    assign push    = bus.wr_pvld & wr_rdy;
    assign pop     = s2_vld & bus.rd_prdy;
    assign adv     = s1_vld & (~s2_vld | pop);
    assign iss     = (unrd != '0) & (~s1_vld | adv);

    assign wr_data = bus.wr_pd;
    assign rd_data = bus.ram_dout;

    assign bus.wr_prdy = wr_rdy;
    assign bus.rd_pvld = s2_vld;
    assign bus.rd_pd   = rd_data;
    assign bus.ram_we  = push;
    assign bus.ram_wa  = wr_ptr;
    assign bus.ram_di  = wr_data;
    assign bus.ram_re  = iss;
    assign bus.ram_ra  = rd_ptr;
    assign bus.ram_ore = adv;

    always_comb begin
        unrd_nxt = unrd;
        occ_nxt  = occ;
        if (push & ~iss) begin
            unrd_nxt = unrd + 1'b1;
        end else if (~push & iss) begin
            unrd_nxt = unrd - 1'b1;
        end
        if (push & ~pop) begin
            occ_nxt = occ + 1'b1;
        end else if (~push & pop) begin
            occ_nxt = occ - 1'b1;
        end
    end

    // A push only becomes visible to issue a cycle later via unrd, so a read never
    // overtakes the write of the same address.
    always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
        if (!nvdla_core_rstn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            occ    <= '0;
            unrd   <= '0;
            s1_vld <= 1'b0;
            s2_vld <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= ptr_inc(wr_ptr);
            end
            if (iss) begin
                rd_ptr <= ptr_inc(rd_ptr);
            end
            s1_vld <= iss | (s1_vld & ~adv);
            s2_vld <= adv | (s2_vld & ~pop);
            unrd   <= unrd_nxt;
            occ    <= occ_nxt;
        end
    end
endmodule
